// File: rtl/game_pkg.sv
// Shared constants and types for the falling-letter game blocks.
package game_pkg;

    localparam logic [7:0]  LETTER_A    = 8'd65;
    localparam int unsigned NUM_LETTERS = 26;

    // Galois right-shift tap mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef struct packed {
        logic [7:0] ch;
        logic [2:0] speed;
        logic [8:0] x;
        logic [9:0] y;
    } spawn_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_PICK,
        ST_OFFER
    } spawn_state_t;

    // Next letter index with wrap from 'Z' back to 'A'.
    function automatic logic [4:0] next_letter(input logic [4:0] c);
        return (c == 5'(NUM_LETTERS - 1)) ? 5'd0 : c + 5'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running every cycle; a zero seed is forced to 1.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Shift right and fold the tap mask in when the outgoing bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INIT;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/letter_spawner.sv
// Falling-letter spawner: one new letter per interval over valid/ready,
// never duplicating a letter that is still on screen.
module letter_spawner
    import game_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int unsigned COLS       = 70,
    parameter int unsigned COL_PITCH  = 9,
    parameter int unsigned MAX_ACTIVE = 8,
    parameter int unsigned INTERVAL   = 50_000_000,
    parameter logic [25:0] EXCLUDE    = 26'h2084900
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] level,
    input  logic       release_valid,
    input  logic [7:0] release_ch,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] ch,
    output logic [2:0] speed,
    output logic [8:0] x,
    output logic [9:0] y,
    output logic [4:0] active_cnt
);

    logic [15:0]  lfsr;
    spawn_state_t state;
    logic [31:0]  ivl_cnt;
    logic [31:0]  term;
    logic [4:0]   cand;
    logic [4:0]   tries;
    spawn_t       rec;
    logic [25:0]  active_mask;

    logic [4:0]   cand_start;
    logic [1:0]   spd_mod;
    logic [3:0]   speed_sum;
    logic [2:0]   speed_val;
    logic [11:0]  col_idx;
    logic [9:0]   y_val;
    logic         cand_blocked;

    logic [4:0]   rel_idx;
    logic         rel_in_range;
    logic         rel_hit;
    logic         accept;
    logic [25:0]  mask_next;
    logic [4:0]   cnt_next;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Constant-divisor reductions of the current LFSR state and the level-scaled terminal count.
    always_comb begin
        term         = (INTERVAL >> level) - 32'd1;
        cand_start   = 5'(lfsr[7:0] % 8'(NUM_LETTERS));
        spd_mod      = 2'(lfsr[15:8] % 8'd3);
        speed_sum    = 4'd1 + 4'(spd_mod) + 4'(level);
        speed_val    = (speed_sum > 4'd7) ? 3'd7 : speed_sum[2:0];
        col_idx      = lfsr[11:0] % 12'(COLS);
        y_val        = 10'(col_idx * 12'(COL_PITCH));
        cand_blocked = active_mask[cand] | EXCLUDE[cand];
    end

    // Accept/release decode and the next occupancy mask and count.
    // A release naming the letter being accepted finds its bit still clear,
    // so it falls out as ignored and the accept leaves the bit set.
    always_comb begin
        rel_idx      = 5'(release_ch - LETTER_A);
        rel_in_range = (release_ch >= LETTER_A) &&
                       (release_ch <= LETTER_A + 8'(NUM_LETTERS - 1));
        rel_hit      = release_valid && rel_in_range && active_mask[rel_idx];
        accept       = (state == ST_OFFER) && out_valid && out_ready;
        mask_next    = active_mask;
        cnt_next     = active_cnt;
        if (rel_hit) begin
            mask_next[rel_idx] = 1'b0;
        end
        if (accept) begin
            mask_next[cand] = 1'b1;
        end
        if (accept && !rel_hit) begin
            cnt_next = active_cnt + 5'd1;
        end else if (!accept && rel_hit) begin
            cnt_next = active_cnt - 5'd1;
        end
    end

    // On-screen letter bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_mask <= '0;
            active_cnt  <= '0;
        end else begin
            active_mask <= mask_next;
            active_cnt  <= cnt_next;
        end
    end

    // Spawn FSM: interval wait, linear-probe letter pick, then hold the offer until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_WAIT;
            ivl_cnt   <= '0;
            cand      <= '0;
            tries     <= '0;
            out_valid <= 1'b0;
            rec       <= '{ch: LETTER_A, speed: 3'd1, x: '0, y: '0};
        end else begin
            case (state)
                ST_WAIT: begin
                    if (enable) begin
                        if (ivl_cnt >= term) begin
                            ivl_cnt <= '0;
                            if (active_cnt < 5'(MAX_ACTIVE)) begin
                                state <= ST_PICK;
                                cand  <= cand_start;
                                tries <= '0;
                            end
                        end else begin
                            ivl_cnt <= ivl_cnt + 32'd1;
                        end
                    end
                end
                ST_PICK: begin
                    if (!cand_blocked) begin
                        state     <= ST_OFFER;
                        out_valid <= 1'b1;
                        rec       <= '{ch: LETTER_A + {3'b000, cand},
                                       speed: speed_val, x: '0, y: y_val};
                    end else if (tries == 5'(NUM_LETTERS - 1)) begin
                        state   <= ST_WAIT;
                        ivl_cnt <= '0;
                    end else begin
                        cand  <= next_letter(cand);
                        tries <= tries + 5'd1;
                    end
                end
                ST_OFFER: begin
                    if (out_ready) begin
                        state     <= ST_WAIT;
                        out_valid <= 1'b0;
                        ivl_cnt   <= '0;
                    end
                end
                default: begin
                    state     <= ST_WAIT;
                    out_valid <= 1'b0;
                    ivl_cnt   <= '0;
                end
            endcase
        end
    end

    assign ch    = rec.ch;
    assign speed = rec.speed;
    assign x     = rec.x;
    assign y     = rec.y;

endmodule

// File: tb/tb_letter_spawner.sv
// Directed bench for letter_spawner: two instances, one with the normal
// letter set and one where only 'A' may spawn.
module tb_letter_spawner;

    localparam logic [25:0] EXCL_A = 26'h20C4100;  // I, O, S, T, Z
    localparam logic [25:0] EXCL_B = 26'h3FFFFFE;  // only 'A' allowed

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, relv_a, rdy_a, ov_a;
    logic [1:0] lvl_a;
    logic [7:0] relc_a, ch_a;
    logic [2:0] sp_a;
    logic [8:0] x_a;
    logic [9:0] y_a;
    logic [4:0] cnt_a;

    logic       rst_b, en_b, relv_b, rdy_b, ov_b;
    logic [1:0] lvl_b;
    logic [7:0] relc_b, ch_b;
    logic [2:0] sp_b;
    logic [8:0] x_b;
    logic [9:0] y_b;
    logic [4:0] cnt_b;

    letter_spawner #(.SEED(16'hACE1), .COLS(70), .COL_PITCH(9), .MAX_ACTIVE(8),
                     .INTERVAL(16), .EXCLUDE(EXCL_A)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .level(lvl_a),
        .release_valid(relv_a), .release_ch(relc_a),
        .out_valid(ov_a), .out_ready(rdy_a),
        .ch(ch_a), .speed(sp_a), .x(x_a), .y(y_a), .active_cnt(cnt_a)
    );

    letter_spawner #(.SEED(16'h1234), .COLS(70), .COL_PITCH(9), .MAX_ACTIVE(8),
                     .INTERVAL(64), .EXCLUDE(EXCL_B)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .level(lvl_b),
        .release_valid(relv_b), .release_ch(relc_b),
        .out_valid(ov_b), .out_ready(rdy_b),
        .ch(ch_b), .speed(sp_b), .x(x_b), .y(y_b), .active_cnt(cnt_b)
    );

    int checks   = 0;
    int failures = 0;
    bit [25:0] model = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit letter_ok(input logic [7:0] c);
        int i;
        if (c < 8'd65 || c > 8'd90) return 1'b0;
        i = int'(c) - 65;
        return !EXCL_A[i];
    endfunction

    function automatic logic [7:0] first_active();
        for (int i = 0; i < 26; i++) begin
            if (model[i]) return 8'(65 + i);
        end
        return 8'd0;
    endfunction

    task automatic wait_valid(input bit sel, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = sel ? (ov_b === 1'b1) : (ov_a === 1'b1);
        end
    endtask

    // Checks the offered record, accepts it (optionally with a release in the same cycle).
    task automatic do_accept_a(input bit rel, input logic [7:0] rc);
        logic [7:0] c;
        int lo, hi, ci, ri;
        c  = ch_a;
        lo = 1 + int'(lvl_a);
        hi = (3 + int'(lvl_a) > 7) ? 7 : 3 + int'(lvl_a);
        chk("acc_letter_legal", letter_ok(c), 1);
        ci = int'(c) - 65;
        if (ci >= 0 && ci < 26) chk("acc_no_dup", model[ci], 0);
        chk("acc_speed_range", (int'(sp_a) >= lo && int'(sp_a) <= hi), 1);
        chk("acc_x", x_a, 0);
        chk("acc_y_col", (y_a % 9 == 0 && y_a <= 621), 1);
        rdy_a  = 1'b1;
        relv_a = rel;
        relc_a = rc;
        @(negedge clk);
        rdy_a  = 1'b0;
        relv_a = 1'b0;
        ri = int'(rc) - 65;
        if (rel && ri >= 0 && ri < 26 && rc != c && model[ri]) model[ri] = 1'b0;
        if (ci >= 0 && ci < 26) model[ci] = 1'b1;
        chk("acc_valid_drop", ov_a, 0);
        chk("acc_cnt", cnt_a, $countones(model));
    endtask

    task automatic do_release_a(input logic [7:0] rc);
        int ri;
        relv_a = 1'b1;
        relc_a = rc;
        @(negedge clk);
        relv_a = 1'b0;
        ri = int'(rc) - 65;
        if (ri >= 0 && ri < 26 && model[ri]) model[ri] = 1'b0;
        chk("rel_cnt", cnt_a, $countones(model));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        bit ok, stable, seen;
        logic [7:0] cap_ch, off_ch;
        logic [2:0] cap_sp;
        logic [9:0] cap_y;

        rst_a = 1; en_a = 1; lvl_a = 0; relv_a = 0; relc_a = 0; rdy_a = 0;
        rst_b = 1; en_b = 1; lvl_b = 0; relv_b = 0; relc_b = 0; rdy_b = 0;
        repeat (3) @(negedge clk);

        chk("rst_valid", ov_a, 0);
        chk("rst_ch", ch_a, 65);
        chk("rst_speed", sp_a, 1);
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_cnt", cnt_a, 0);

        // First spawn latency and fields.
        rst_a = 0;
        wait_valid(0, 44, n, ok);
        chk("first_spawn_seen", ok, 1);
        if (ok) do_accept_a(0, 8'd0);

        // Backpressure: offer held stable for 100 cycles.
        wait_valid(0, 60, n, ok);
        chk("bp_spawn_seen", ok, 1);
        cap_ch = ch_a; cap_sp = sp_a; cap_y = y_a;
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (ov_a !== 1'b1 || ch_a !== cap_ch || sp_a !== cap_sp ||
                y_a !== cap_y || x_a !== 9'd0) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        if (ok) do_accept_a(0, 8'd0);

        // Fill up to the active limit.
        for (int k = 0; k < 6; k++) begin
            wait_valid(0, 60, n, ok);
            chk("fill_spawn_seen", ok, 1);
            if (ok) do_accept_a(0, 8'd0);
        end
        chk("limit_cnt", cnt_a, 8);
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (ov_a !== 1'b0) seen = 1'b1;
        end
        chk("limit_no_spawn", seen, 0);

        // Release one active letter with enable low; then non-active releases.
        en_a = 1'b0;
        do_release_a(first_active());
        chk("rel_cnt_7", cnt_a, 7);
        do_release_a("I");
        do_release_a(8'h30);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (ov_a !== 1'b0) seen = 1'b1;
        end
        chk("enable_freeze", seen, 0);
        en_a = 1'b1;
        wait_valid(0, 60, n, ok);
        chk("respawn_seen", ok, 1);
        if (ok) do_accept_a(0, 8'd0);

        // Accept together with release of a different letter: count unchanged.
        do_release_a(first_active());
        wait_valid(0, 60, n, ok);
        chk("sim_spawn_seen", ok, 1);
        if (ok) do_accept_a(1, first_active());
        chk("sim_diff_cnt", cnt_a, 7);

        // Accept together with release of the same letter: release ignored.
        wait_valid(0, 60, n, ok);
        chk("self_spawn_seen", ok, 1);
        off_ch = ch_a;
        if (ok) do_accept_a(1, off_ch);
        chk("self_cnt", cnt_a, 8);
        do_release_a(off_ch);
        chk("self_bit_set", cnt_a, 7);

        // Level 3 speed range.
        lvl_a = 2'd3;
        wait_valid(0, 60, n, ok);
        chk("lvl3_spawn_seen", ok, 1);
        if (ok) do_accept_a(0, 8'd0);

        // Reset while offering.
        do_release_a(first_active());
        wait_valid(0, 60, n, ok);
        chk("rstoffer_spawn_seen", ok, 1);
        rst_a = 1'b1;
        rdy_a = 1'b1;
        @(negedge clk);
        chk("rstoffer_valid", ov_a, 0);
        chk("rstoffer_cnt", cnt_a, 0);
        chk("rstoffer_ch", ch_a, 65);
        rst_a = 1'b0;
        rdy_a = 1'b0;
        model = '0;

        // Exhaustion: only 'A' may spawn.
        rst_b = 1'b0;
        wait_valid(1, 100, n, ok);
        chk("exh_first_seen", ok, 1);
        chk("exh_first_ch", ch_b, 65);
        rdy_b = 1'b1;
        @(negedge clk);
        rdy_b = 1'b0;
        chk("exh_valid_drop", ov_b, 0);
        chk("exh_cnt_1", cnt_b, 1);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (ov_b !== 1'b0) seen = 1'b1;
        end
        chk("exh_no_spawn", seen, 0);
        chk("exh_cnt_hold", cnt_b, 1);

        lvl_b  = 2'd3;
        relv_b = 1'b1;
        relc_b = 8'd65;
        @(negedge clk);
        relv_b = 1'b0;
        chk("exh_rel_cnt", cnt_b, 0);
        wait_valid(1, 100, n, ok);
        chk("exh_respawn_seen", ok, 1);
        chk("exh_respawn_ch", ch_b, 65);

        // Level-3 spacing at INTERVAL=64: accept, release at once, measure gap.
        rdy_b = 1'b1;
        @(negedge clk);
        rdy_b  = 1'b0;
        relv_b = 1'b1;
        relc_b = 8'd65;
        @(negedge clk);
        relv_b = 1'b0;
        wait_valid(1, 40, m, ok);
        chk("lvl3_gap_seen", ok, 1);
        chk("lvl3_gap_range", (1 + m >= 9 && 1 + m <= 34), 1);
        chk("lvl3_speed_b", (sp_b >= 3'd4 && sp_b <= 3'd6), 1);
        chk("lvl3_ch_b", ch_b, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
